// File: rtl/harris_window_gen_if.sv
// Pixel-in / window-out bundle between the raster source and the 3x3 window generator.
// master = pixel producer, slave = window generator.
interface harris_window_gen_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CW    = 10
);
    logic [PIX_W-1:0]   pixel;
    logic               pixel_valid;
    logic [9*PIX_W-1:0] window;
    logic               win_valid;
    logic [CW-1:0]      win_row;
    logic [CW-1:0]      win_col;
    logic               frame_done;

    modport master (
        output pixel, pixel_valid,
        input  window, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pixel, pixel_valid,
        output window, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/harris_window_gen.sv
// 3x3 sliding-window generator: two circular line buffers feed a 3x3 shift array;
// interior windows are registered out one clock after the pixel that completes them.
module harris_window_gen #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    harris_window_gen_if.slave bus
);
    localparam int unsigned   AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned   WIN_W    = 9 * PIX_W;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    logic [PIX_W-1:0] r_lb0 [IMG_W];
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_sr  [9];
    logic [PIX_W-1:0] w_sr_nxt [9];

    logic [CW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [WIN_W-1:0] r_window;
    logic             r_win_valid;
    logic [CW-1:0]    r_win_row;
    logic [CW-1:0]    r_win_col;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_emit;
    logic             w_col_last;
    logic             w_row_last;
    logic [AW-1:0]    w_addr;
    logic [PIX_W-1:0] w_lb0_q;
    logic [PIX_W-1:0] w_lb1_q;
    logic [WIN_W-1:0] w_window_nxt;

    assign w_accept   = reset & bus.pixel_valid;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_emit     = w_accept && (r_row >= TWO) && (r_col >= TWO);
    assign w_addr     = AW'(r_col);
    assign w_lb0_q    = r_lb0[w_addr];
    assign w_lb1_q    = r_lb1[w_addr];

    // Column shift: oldest line (lb1) enters row 0, newest pixel enters row 2.
    always_comb begin
        w_window_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            w_sr_nxt[3*r]     = r_sr[3*r+1];
            w_sr_nxt[3*r + 1] = r_sr[3*r+2];
        end
        w_sr_nxt[2] = w_lb1_q;
        w_sr_nxt[5] = w_lb0_q;
        w_sr_nxt[8] = bus.pixel;
        for (int k = 0; k < 9; k++) begin
            w_window_nxt[k*PIX_W +: PIX_W] = w_sr_nxt[k];
        end
    end

    // Line-buffer RAM carries no reset; stale lines are never emitted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_addr] <= w_lb0_q;
            r_lb0[w_addr] <= bus.pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
            for (int k = 0; k < 9; k++) begin
                r_sr[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 9; k++) begin
                r_sr[k] <= w_sr_nxt[k];
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ONE;
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_window     <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_emit;
            r_frame_done <= w_emit && w_row_last && w_col_last;
            if (w_emit) begin
                r_window  <= w_window_nxt;
                r_win_row <= r_row - ONE;
                r_win_col <= r_col - ONE;
            end
        end
    end

    assign bus.window     = r_window;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_harris_window_gen.sv
// Randomised bench for harris_window_gen against a frame-image reference model.
module tb_harris_window_gen;
    localparam int unsigned W   = 8;
    localparam int unsigned H   = 6;
    localparam int unsigned PW  = 8;
    localparam int unsigned CWL = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    harris_window_gen_if #(.PIX_W(PW), .CW(CWL)) bus ();

    harris_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .CW(CWL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame as a 2-D image plus a raster position.
    int          img [H][W];
    int          mrow = 0;
    int          mcol = 0;
    logic        e_valid = 1'b0;
    logic        e_fd = 1'b0;
    logic [71:0] e_win = '0;
    int          e_row = 0;
    int          e_col = 0;
    int          n_win = 0;
    int          n_fd = 0;
    logic [71:0] first_cap = '0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected ramp window centred at (cr,cc) for a frame whose pixel is base+row*W+col.
    function automatic logic [71:0] ramp_win(input int base, input int cr, input int cc);
        logic [71:0] res;
        res = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int c = 0; c < 3; c++)
                res[(3*rr+c)*8 +: 8] = 8'(base + (cr - 1 + rr) * int'(W) + (cc - 1 + c));
        return res;
    endfunction

    task automatic step(input logic v, input logic [7:0] p, input logic rst);
        @(negedge clk);
        reset           = rst;
        bus.pixel_valid = v;
        bus.pixel       = p;
        @(posedge clk);
        if (!rst) begin
            mrow = 0; mcol = 0;
            e_valid = 1'b0; e_fd = 1'b0; e_win = '0; e_row = 0; e_col = 0;
        end else if (v) begin
            img[mrow][mcol] = int'(p);
            e_valid = (mrow >= 2) && (mcol >= 2);
            e_fd    = e_valid && (mrow == int'(H) - 1) && (mcol == int'(W) - 1);
            if (e_valid) begin
                for (int rr = 0; rr < 3; rr++)
                    for (int c = 0; c < 3; c++)
                        e_win[(3*rr+c)*8 +: 8] = 8'(img[mrow-2+rr][mcol-2+c]);
                e_row = mrow - 1;
                e_col = mcol - 1;
            end
            if (mcol == int'(W) - 1) begin
                mcol = 0;
                mrow = (mrow == int'(H) - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end else begin
            e_valid = 1'b0;
            e_fd    = 1'b0;
        end
        #1;
        check("win_valid",  72'(bus.win_valid),  72'(e_valid));
        check("frame_done", 72'(bus.frame_done), 72'(e_fd));
        check("window",     bus.window,          e_win);
        check("win_row",    72'(bus.win_row),    72'(e_row));
        check("win_col",    72'(bus.win_col),    72'(e_col));
        if (bus.win_valid)  n_win++;
        if (bus.frame_done) n_fd++;
    endtask

    task automatic send_frame(input int base, input int maxgap);
        n_win = 0;
        n_fd  = 0;
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                repeat ($urandom_range(maxgap, 0)) step(1'b0, 8'($urandom), 1'b1);
                step(1'b1, 8'(base + r * int'(W) + c), 1'b1);
                if (r == 2 && c == 2) begin
                    first_cap = bus.window;
                    check("first_win", bus.window, ramp_win(base, 1, 1));
                    check("first_row", 72'(bus.win_row), 72'(1));
                    check("first_col", 72'(bus.win_col), 72'(1));
                end
                if (r == 2 && c == 7) check("row_end_win", bus.window, ramp_win(base, 1, 6));
                if (r == 3 && c < 2)  check("no_cross_line", 72'(bus.win_valid), 72'(0));
                if (r == 3 && c == 2) check("next_line_win", bus.window, ramp_win(base, 2, 1));
                if (r == int'(H) - 1 && c == int'(W) - 1) begin
                    check("fd_pulse", 72'(bus.frame_done), 72'(1));
                    check("fd_win", bus.window, ramp_win(base, 4, 6));
                end
            end
        end
        check("windows_per_frame", 72'(n_win), 72'((W - 2) * (H - 2)));
        check("fd_per_frame",      72'(n_fd),  72'(1));
    endtask

    initial begin
        logic [71:0] lit;
        lit = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        reset           = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel       = '0;

        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Single frame, no gaps.
        send_frame(0, 0);
        check("first_win_literal", first_cap, lit);

        // Same frame with random bubbles.
        send_frame(0, 5);

        // Back-to-back frames, second ramp offset by 100.
        send_frame(0, 0);
        send_frame(100, 0);

        // Abort mid-frame after 30 accepts, then a clean frame.
        for (int i = 0; i < 30; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b1, 8'hAA, 1'b0);
        send_frame(0, 0);

        // Reset held with pixel_valid high accepts nothing.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h55, 1'b0);
        send_frame(0, 2);

        repeat (3) step(1'b0, 8'($urandom), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
